// File: rtl/ram_loader.sv
// Streams a block of source words into a RAM window starting at base_adr.
// Write-side outputs are all-zero when idle so the consumer can OR its own read address in.
module ram_loader #(
   parameter int                  ACP_WIDTH = 64,
   parameter int                  REGSEL_W  = 12,
   parameter int                  MEMSEL_W  = 3,
   parameter logic [MEMSEL_W-1:0] MEM_ADDR  = '0
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  start,
   input  logic [REGSEL_W-1:0]   base_adr,
   input  logic [REGSEL_W:0]     length,
   input  logic                  abort,
   input  logic                  s_valid,
   input  logic [ACP_WIDTH-1:0]  s_data,
   output logic                  s_ready,
   output logic [ACP_WIDTH-1:0]  ram_din,
   output logic [REGSEL_W-1:0]   ram_reg_adr,
   output logic [MEMSEL_W-1:0]   ram_mem_adr,
   output logic                  ram_we,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;

   localparam logic [REGSEL_W:0] DEPTH = {1'b1, {REGSEL_W{1'b0}}};
   localparam logic [REGSEL_W:0] ONE   = {{REGSEL_W{1'b0}}, 1'b1};

   state_t                r_state, w_next;
   logic [REGSEL_W-1:0]   r_addr;
   logic [REGSEL_W:0]     r_rem;
   logic [ACP_WIDTH-1:0]  r_din;
   logic [REGSEL_W-1:0]   r_reg_adr;
   logic [MEMSEL_W-1:0]   r_mem_adr;
   logic                  r_we;
   logic                  r_err;

   logic w_len_ok, w_accept, w_reject, w_hs, w_wr;

   assign w_len_ok = (length != '0) && (length <= DEPTH);
   assign w_accept = (r_state == IDLE) && start && w_len_ok;
   assign w_reject = (r_state == IDLE) && start && !w_len_ok;
   assign w_hs     = s_valid && (r_state == LOAD);
   // An abort in the same cycle as a handshake drops that word.
   assign w_wr     = w_hs && !abort;

   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (w_accept) w_next = LOAD;
         LOAD: begin
            if (abort)                      w_next = IDLE;
            else if (w_hs && (r_rem == ONE)) w_next = FLUSH;
         end
         FLUSH:   w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         r_state   <= IDLE;
         r_addr    <= '0;
         r_rem     <= '0;
         r_din     <= '0;
         r_reg_adr <= '0;
         r_mem_adr <= '0;
         r_we      <= 1'b0;
         r_err     <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_addr <= base_adr;
            r_rem  <= length;
         end else if (w_wr) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - ONE;
         end
         r_we      <= w_wr;
         r_din     <= w_wr ? s_data : '0;
         r_reg_adr <= w_wr ? r_addr : '0;
         r_mem_adr <= w_wr ? MEM_ADDR : '0;
         r_err     <= w_reject;
      end
   end

   assign s_ready     = (r_state == LOAD);
   assign busy        = (r_state != IDLE);
   // The final write lands in the FLUSH cycle, so done lines up with it.
   assign done        = (r_state == FLUSH);
   assign ram_we      = r_we;
   assign ram_din     = r_din;
   assign ram_reg_adr = r_reg_adr;
   assign ram_mem_adr = r_mem_adr;
   assign err         = r_err;

endmodule

// File: tb/tb_ram_loader.sv
// Randomized bench for ram_loader: a per-load expected-output table is built from
// the transfer rules and compared against the DUT outputs cycle by cycle.
module tb_ram_loader;
   localparam int NC = 72;
   localparam logic [2:0] MEMV = 3'b101;

   logic        CLK = 1'b0, RST_N = 1'b0, start = 1'b0, abort = 1'b0, s_valid = 1'b0;
   logic [11:0] base_adr = '0;
   logic [12:0] length = '0;
   logic [63:0] s_data = '0;
   logic        s_ready, ram_we, busy, done, err;
   logic [63:0] ram_din;
   logic [11:0] ram_reg_adr;
   logic [2:0]  ram_mem_adr;

   int n_tests = 0, n_fail = 0;

   logic        v [NC];
   logic [63:0] d [NC];
   logic        e_busy [NC], e_rdy [NC], e_done [NC], e_we [NC];
   logic [11:0] e_adr [NC];
   logic [63:0] e_din [NC];

   ram_loader #(.ACP_WIDTH(64), .REGSEL_W(12), .MEMSEL_W(3), .MEM_ADDR(MEMV)) dut (
      .CLK(CLK), .RST_N(RST_N), .start(start), .base_adr(base_adr), .length(length),
      .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
      .ram_din(ram_din), .ram_reg_adr(ram_reg_adr), .ram_mem_adr(ram_mem_adr),
      .ram_we(ram_we), .busy(busy), .done(done), .err(err));

   always #5 CLK = ~CLK;

   function automatic logic [83:0] obs();
      return {busy, s_ready, done, err, ram_we, ram_mem_adr, ram_reg_adr, ram_din};
   endfunction

   task automatic fill(input bit all_valid);
      for (int c = 0; c < NC; c++) begin
         v[c] = all_valid ? 1'b1 : ((c >= 40) ? 1'b1 : 1'($urandom % 2));
         d[c] = {$urandom, $urandom};
      end
   endtask

   // ab: abort cycle, rs: reset cycle, sb: cycle of a stray start; -1 disables.
   // Cycle 0 is the first cycle after the accepted start.
   task automatic run_load(input string name, input logic [11:0] b, input logic [12:0] len,
                           input int ab, input int rs, input int sb);
      int k, last;
      logic ld, fl;
      logic [83:0] ex;
      for (int c = 0; c < NC; c++) begin
         e_busy[c] = 0; e_rdy[c] = 0; e_done[c] = 0; e_we[c] = 0; e_adr[c] = '0; e_din[c] = '0;
      end
      ld = 1; fl = 0; k = 0; last = NC - 2;
      for (int c = 0; c < NC - 1; c++) begin
         e_busy[c] = ld | fl; e_rdy[c] = ld; e_done[c] = fl;
         if (!ld && !fl) begin last = c; break; end
         if (c == rs) begin ld = 0; fl = 0; end
         else if (fl) fl = 0;
         else if (c == ab) ld = 0;
         else if (v[c]) begin
            e_we[c+1] = 1; e_adr[c+1] = b + k[11:0]; e_din[c+1] = d[c];
            k++;
            if (k == int'(len)) begin ld = 0; fl = 1; end
         end
      end
      @(negedge CLK);
      start = 1; base_adr = b; length = len; s_valid = 0; abort = 0;
      @(negedge CLK);
      start = 0; base_adr = 12'($urandom); length = 13'($urandom);
      for (int c = 0; c <= last; c++) begin
         ex = {e_busy[c], e_rdy[c], e_done[c], 1'b0, e_we[c], e_we[c] ? MEMV : 3'b000, e_adr[c], e_din[c]};
         n_tests++;
         if (obs() !== ex) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, c, obs(), ex);
         end
         s_valid = v[c]; s_data = d[c]; abort = (c == ab); RST_N = (c != rs);
         start = (c == sb) && (c < last);
         if (start) length = '0;
         @(negedge CLK);
      end
      s_valid = 0; abort = 0; RST_N = 1; start = 0;
   endtask

   task automatic test_reset();
      RST_N = 0; start = 1; length = 13'd4; s_valid = 1; abort = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge CLK);
         n_tests++;
         if (obs() !== 84'd0) begin
            n_fail++;
            $display("FAIL reset %0d: got %h expected 0", i, obs());
         end
      end
      RST_N = 1; start = 0; s_valid = 0;
      @(negedge CLK);
   endtask

   task automatic test_reject(input logic [12:0] len);
      logic [83:0] ex;
      @(negedge CLK);
      start = 1; length = len; abort = 1;
      @(negedge CLK);
      start = 0; abort = 0;
      ex = 84'd0; ex[80] = 1'b1;
      n_tests++;
      if (obs() !== ex) begin
         n_fail++;
         $display("FAIL reject len=%0d pulse: got %h expected %h", len, obs(), ex);
      end
      @(negedge CLK);
      n_tests++;
      if (obs() !== 84'd0) begin
         n_fail++;
         $display("FAIL reject len=%0d after: got %h expected 0", len, obs());
      end
   endtask

   task automatic test_basic();
      fill(1);
      for (int c = 0; c < NC; c++) d[c] = 64'hA0 + 64'(c);
      run_load("basic", 12'h010, 13'd4, -1, -1, -1);
      fill(1);
      run_load("abort_in_flush", 12'h100, 13'd4, 4, -1, 1);
   endtask

   task automatic test_wrap();
      fill(1);
      run_load("wrap", 12'hFFE, 13'd4, -1, -1, -1);
   endtask

   task automatic test_stall();
      fill(0);
      v[0] = 1; v[1] = 0; v[2] = 0; v[3] = 1; v[4] = 0; v[5] = 1;
      run_load("stall", 12'h200, 13'd3, -1, -1, -1);
   endtask

   task automatic test_abort();
      fill(1);
      run_load("abort", 12'h300, 13'd8, 2, -1, -1);
      fill(1);
      run_load("after_abort", 12'h055, 13'd1, -1, -1, -1);
      fill(1);
      run_load("max_len_abort", 12'h7F0, 13'd4096, 3, -1, -1);
   endtask

   task automatic test_reset_mid();
      fill(1);
      run_load("reset_mid", 12'h400, 13'd6, -1, 2, -1);
   endtask

   task automatic test_random();
      for (int i = 0; i < 8; i++) begin
         fill(0);
         run_load("random", 12'($urandom), 13'($urandom_range(1, 16)),
                  ($urandom % 4 == 0) ? int'($urandom_range(0, 20)) : -1, -1,
                  ($urandom % 3 == 0) ? int'($urandom_range(0, 5)) : -1);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_reject(13'd0);
      test_reject(13'd4097);
      test_abort();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
